dn_benes: RTL and testbench

- N-lane Benes distribution network for the sparse tensor-core datapath.
- Routes N input words of DW_DATA bits to N output lanes.
- Each 2x2 switch is configured per level and supports multicast (broadcast).
- Configuration is captured in a register on set_en; the routed result is captured in an output register on route_en.

---
 rtl/dn_benes_pkg.sv | 22 ++
 rtl/benes_switch.sv | 44 ++++
 rtl/dn_benes_core.sv | 78 +++++++
 rtl/dn_benes.sv | 59 +++++
 tb/tb_dn_benes.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/dn_benes_pkg.sv
// Shared definitions for the Benes distribution network: switch modes and level count.
// Latency: none (constants and a constant function only).
// Backpressure: not applicable.
package dn_benes_pkg;

    // 2x2 switch modes; input 0 is the even (upper) lane
    localparam logic [1:0] SW_PASS  = 2'b00;  // o0=i0, o1=i1
    localparam logic [1:0] SW_CROSS = 2'b01;  // o0=i1, o1=i0
    localparam logic [1:0] SW_BC_UP = 2'b10;  // o0=o1=i0
    localparam logic [1:0] SW_BC_LO = 2'b11;  // o0=o1=i1

    // Number of switch levels of an n-lane Benes network: 2*log2(n)-1
    function automatic int n_levels(input int n);
        int lg;
        lg = 0;
        while ((1 << lg) < n) begin
            lg = lg + 1;
        end
        return 2 * lg - 1;
    endfunction

endpackage

// File: rtl/benes_switch.sv
// 2x2 routing element with pass, cross and the two broadcast modes.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs and mode directly.
module benes_switch
    import dn_benes_pkg::*;
#(
    parameter int DW_DATA = 8
) (
    input  logic [1:0]         mode,
    input  logic [DW_DATA-1:0] i0,
    input  logic [DW_DATA-1:0] i1,
    output logic [DW_DATA-1:0] o0,
    output logic [DW_DATA-1:0] o1
);

    // Select each output from the upper or lower input according to mode
    always_comb begin
        o0 = i0;
        o1 = i1;
        case (mode)
            SW_PASS: begin
                o0 = i0;
                o1 = i1;
            end
            SW_CROSS: begin
                o0 = i1;
                o1 = i0;
            end
            SW_BC_UP: begin
                o0 = i0;
                o1 = i0;
            end
            SW_BC_LO: begin
                o0 = i1;
                o1 = i1;
            end
            default: begin
                o0 = i0;
                o1 = i1;
            end
        endcase
    end

endmodule

// File: rtl/dn_benes_core.sv
// Recursive combinational Benes network: input level, two half-size subnetworks, output level.
// Latency: purely combinational from din and cfg.
// Backpressure: none.
module dn_benes_core
    import dn_benes_pkg::*;
#(
    parameter int DW_DATA  = 8,
    parameter int N        = 8,
    parameter int N_LEVELS = n_levels(N)
) (
    input  logic [N_LEVELS*N-1:0] cfg,
    input  logic [DW_DATA*N-1:0]  din,
    output logic [DW_DATA*N-1:0]  dout
);

    generate
        if (N == 2) begin : g_leaf
            // A two-lane network is a single switch
            benes_switch #(.DW_DATA(DW_DATA)) u_sw (
                .mode (cfg[1:0]),
                .i0   (din[0 +: DW_DATA]),
                .i1   (din[DW_DATA +: DW_DATA]),
                .o0   (dout[0 +: DW_DATA]),
                .o1   (dout[DW_DATA +: DW_DATA])
            );
        end else begin : g_rec
            localparam int H      = N / 2;
            localparam int SUB_LV = N_LEVELS - 2;

            logic [DW_DATA*H-1:0] top_in;
            logic [DW_DATA*H-1:0] top_out;
            logic [DW_DATA*H-1:0] bot_in;
            logic [DW_DATA*H-1:0] bot_out;
            logic [SUB_LV*H-1:0]  top_cfg;
            logic [SUB_LV*H-1:0]  bot_cfg;

            // Middle levels: the top subnetwork owns the low half of each
            // level's config bits, the bottom subnetwork the high half
            for (genvar j = 0; j < SUB_LV; j++) begin : g_cfg
                assign top_cfg[j*H +: H] = cfg[(j+1)*N +: H];
                assign bot_cfg[j*H +: H] = cfg[(j+1)*N + H +: H];
            end

            for (genvar s = 0; s < H; s++) begin : g_sw
                // Input level: output 0 feeds top lane s, output 1 feeds bottom lane s
                benes_switch #(.DW_DATA(DW_DATA)) u_first (
                    .mode (cfg[2*s +: 2]),
                    .i0   (din[(2*s)*DW_DATA +: DW_DATA]),
                    .i1   (din[(2*s+1)*DW_DATA +: DW_DATA]),
                    .o0   (top_in[s*DW_DATA +: DW_DATA]),
                    .o1   (bot_in[s*DW_DATA +: DW_DATA])
                );

                // Output level: gathers top lane s and bottom lane s back to lanes 2s/2s+1
                benes_switch #(.DW_DATA(DW_DATA)) u_last (
                    .mode (cfg[(N_LEVELS-1)*N + 2*s +: 2]),
                    .i0   (top_out[s*DW_DATA +: DW_DATA]),
                    .i1   (bot_out[s*DW_DATA +: DW_DATA]),
                    .o0   (dout[(2*s)*DW_DATA +: DW_DATA]),
                    .o1   (dout[(2*s+1)*DW_DATA +: DW_DATA])
                );
            end

            dn_benes_core #(.DW_DATA(DW_DATA), .N(H), .N_LEVELS(SUB_LV)) u_top (
                .cfg  (top_cfg),
                .din  (top_in),
                .dout (top_out)
            );

            dn_benes_core #(.DW_DATA(DW_DATA), .N(H), .N_LEVELS(SUB_LV)) u_bot (
                .cfg  (bot_cfg),
                .din  (bot_in),
                .dout (bot_out)
            );
        end
    endgenerate

endmodule

// File: rtl/dn_benes.sv
// N-lane Benes distribution network with multicast switches, registered config and output.
// Latency: config usable one edge after set_en; out updates on the route_en edge.
// Backpressure: none; in is sampled only on route_en edges.
module dn_benes
    import dn_benes_pkg::*;
#(
    parameter int DW_DATA  = 8,
    parameter int N        = 8,
    parameter int N_LEVELS = n_levels(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic                  route_en,
    input  logic [N_LEVELS*N-1:0] route_signals,
    input  logic [DW_DATA*N-1:0]  in,
    output logic [DW_DATA*N-1:0]  out
);

    logic [N_LEVELS*N-1:0] cfg_q;
    logic [N_LEVELS*N-1:0] cfg_d;
    logic [DW_DATA*N-1:0]  out_q;
    logic [DW_DATA*N-1:0]  out_d;
    logic [DW_DATA*N-1:0]  net_out;

    // The network always routes with the registered config, so a config
    // loaded in the same cycle as route_en only applies from the next cycle
    dn_benes_core #(.DW_DATA(DW_DATA), .N(N), .N_LEVELS(N_LEVELS)) u_core (
        .cfg  (cfg_q),
        .din  (in),
        .dout (net_out)
    );

    // Load enables for the config and output registers
    always_comb begin
        cfg_d = cfg_q;
        out_d = out_q;
        if (set_en) begin
            cfg_d = route_signals;
        end
        if (route_en) begin
            out_d = net_out;
        end
    end

    // State update; reset clears to identity routing and a zero output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_q <= '0;
            out_q <= '0;
        end else begin
            cfg_q <= cfg_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_dn_benes.sv
// Self-checking bench for dn_benes: directed cases with literal expectations plus random traffic.
// A lane-array model of the Benes topology tracks config and out every cycle.
// Inputs change 2 time units after the rising edge; outputs are compared on the falling edge.
module tb_dn_benes;

    localparam int DW = 8;
    localparam int N  = 8;
    localparam int LG = 3;
    localparam int L  = 2 * LG - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            set_en = 1'b0;
    logic            route_en = 1'b0;
    logic [L*N-1:0]  route_signals = '0;
    logic [DW*N-1:0] din = '0;
    logic [DW*N-1:0] out;

    logic [L*N-1:0]  exp_cfg = '0;
    logic [DW*N-1:0] exp_out = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    dn_benes #(.DW_DATA(DW), .N(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .set_en        (set_en),
        .route_en      (route_en),
        .route_signals (route_signals),
        .in            (din),
        .out           (out)
    );

    always #5 clk = ~clk;

    // Route lane-by-lane, level-by-level. At level l the network is split
    // into blocks of size b; on the way in a block's switch s sends its outputs
    // to block lanes s and b/2+s, on the way out it collects from those lanes.
    function automatic logic [DW*N-1:0] model_route(input logic [DW*N-1:0] d,
                                                    input logic [L*N-1:0] c);
        logic [DW-1:0] cur [N];
        logic [DW-1:0] nxt [N];
        logic [DW*N-1:0] r;
        for (int i = 0; i < N; i++) cur[i] = d[i*DW +: DW];
        for (int i = 0; i < N; i++) nxt[i] = '0;
        for (int l = 0; l < L; l++) begin
            int b;
            b = N >> ((l < LG) ? l : (L - 1 - l));
            for (int sw = 0; sw < N / 2; sw++) begin
                int base;
                int s;
                logic [1:0] m;
                logic [DW-1:0] a0, a1, y0, y1;
                base = ((2 * sw) / b) * b;
                s    = ((2 * sw) % b) / 2;
                m    = c[l*N + 2*sw +: 2];
                if (l < LG) begin
                    a0 = cur[base + 2*s];
                    a1 = cur[base + 2*s + 1];
                end else begin
                    a0 = cur[base + s];
                    a1 = cur[base + b/2 + s];
                end
                case (m)
                    2'd0: begin y0 = a0; y1 = a1; end
                    2'd1: begin y0 = a1; y1 = a0; end
                    2'd2: begin y0 = a0; y1 = a0; end
                    default: begin y0 = a1; y1 = a1; end
                endcase
                if (l < LG) begin
                    nxt[base + s]       = y0;
                    nxt[base + b/2 + s] = y1;
                end else begin
                    nxt[base + 2*s]     = y0;
                    nxt[base + 2*s + 1] = y1;
                end
            end
            for (int i = 0; i < N; i++) cur[i] = nxt[i];
        end
        for (int i = 0; i < N; i++) r[i*DW +: DW] = cur[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [DW*N-1:0] got,
                         input logic [DW*N-1:0] want);
        n_cmp = n_cmp + 1;
        if (got !== want) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: out=%h expected=%h at %0t", name, got, want, $time);
        end
    endtask

    // Reference state: out uses the config held before this edge
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_cfg <= '0;
            exp_out <= '0;
        end else begin
            if (route_en) exp_out <= model_route(din, exp_cfg);
            if (set_en)   exp_cfg <= route_signals;
        end
    end

    // Continuous comparison against the model
    always @(negedge clk) begin
        check("model", out, exp_out);
    end

    task automatic apply(input logic se, input logic re,
                         input logic [L*N-1:0] rs, input logic [DW*N-1:0] d);
        @(posedge clk);
        #2;
        set_en        = se;
        route_en      = re;
        route_signals = rs;
        din           = d;
    endtask

    localparam logic [DW*N-1:0] SEQ   = 64'h0102030405060708;  // lane0=8 .. lane7=1
    localparam logic [DW*N-1:0] SEQ2  = 64'h1122334455667788;
    localparam logic [L*N-1:0]  C_PASS  = 40'h0;
    localparam logic [L*N-1:0]  C_CROSS = 40'h5555555555;
    localparam logic [L*N-1:0]  C_BCUP  = 40'hAAAAAAAAAA;
    localparam logic [L*N-1:0]  C_BCLO  = 40'hFFFFFFFFFF;
    localparam logic [L*N-1:0]  C_MIX   =
        40'b10100101_10011001_10101010_10011001_10100101;

    initial begin
        logic [63:0] r64;
        logic [63:0] r64b;

        // Reset holds out at zero
        #3;
        check("reset_zero", out, 64'h0);
        @(posedge clk);
        #2;
        reset = 1'b1;

        // Identity routing straight out of reset, without set_en
        apply(1'b0, 1'b1, C_PASS, SEQ);
        apply(1'b0, 1'b0, C_PASS, SEQ);
        check("identity_after_reset", out, SEQ);

        // Asynchronous reset clears nonzero out mid-cycle
        #1;
        reset = 1'b0;
        #1;
        check("async_reset", out, 64'h0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        apply(1'b0, 1'b0, C_PASS, SEQ);
        check("zero_until_route", out, 64'h0);

        // All-pass config
        apply(1'b1, 1'b0, C_PASS, SEQ);
        apply(1'b0, 1'b1, C_PASS, SEQ);
        apply(1'b0, 1'b0, C_PASS, SEQ);
        check("all_pass", out, SEQ);

        // All-cross swaps the two halves
        apply(1'b1, 1'b0, C_CROSS, SEQ);
        apply(1'b0, 1'b1, C_CROSS, SEQ);
        apply(1'b0, 1'b0, C_CROSS, SEQ);
        check("all_cross", out, 64'h0506070801020304);

        // Broadcast upper: lane0 everywhere
        apply(1'b1, 1'b0, C_BCUP, SEQ);
        apply(1'b0, 1'b1, C_BCUP, SEQ);
        apply(1'b0, 1'b0, C_BCUP, SEQ);
        check("bcast_upper", out, 64'h0808080808080808);

        // Broadcast lower: lane7 everywhere
        apply(1'b1, 1'b0, C_BCLO, SEQ);
        apply(1'b0, 1'b1, C_BCLO, SEQ);
        apply(1'b0, 1'b0, C_BCLO, SEQ);
        check("bcast_lower", out, 64'h0101010101010101);

        // set_en and route_en together: old config (cross) used, new one next
        apply(1'b1, 1'b0, C_CROSS, SEQ);
        apply(1'b1, 1'b1, C_BCUP, SEQ);
        apply(1'b0, 1'b1, C_BCUP, SEQ);
        check("same_cycle_old_cfg", out, 64'h0506070801020304);
        apply(1'b0, 1'b0, C_BCUP, SEQ);
        check("next_route_new_cfg", out, 64'h0808080808080808);

        // route_en low: out holds while in changes
        apply(1'b0, 1'b0, C_BCUP, SEQ2);
        apply(1'b0, 1'b0, C_BCUP, 64'hDEADBEEFCAFEF00D);
        check("hold", out, 64'h0808080808080808);

        // Fixed config: out follows in one clock after route_en
        apply(1'b0, 1'b1, C_BCUP, SEQ2);
        apply(1'b0, 1'b0, C_BCUP, SEQ2);
        check("bcast_new_data", out, 64'h8888888888888888);

        // Mixed config, checked against the model, then reset mid-run
        apply(1'b1, 1'b0, C_MIX, SEQ);
        apply(1'b0, 1'b1, C_MIX, SEQ);
        apply(1'b0, 1'b0, C_MIX, SEQ);
        check("mixed_model", out, model_route(SEQ, C_MIX));
        #1;
        reset = 1'b0;
        #1;
        check("mixed_reset", out, 64'h0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        apply(1'b0, 1'b1, C_MIX, SEQ);
        apply(1'b0, 1'b0, C_MIX, SEQ);
        check("cfg_cleared_by_reset", out, SEQ);

        // Random traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            r64  = {$urandom, $urandom};
            r64b = {$urandom, $urandom};
            apply(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                  r64[L*N-1:0], r64b);
            reset = ($urandom_range(0, 49) != 0);
        end
        @(posedge clk);
        #2;
        reset    = 1'b1;
        set_en   = 1'b0;
        route_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
